// File: rtl/i2c_bus_arbiter_if.sv
// i2c_bus_arbiter_if: requester-side and shared-master-side Wishbone signals of the I2C bus arbiter
interface i2c_bus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   i_req;
  logic [NUM_REQ-1:0]   o_gnt;
  logic [3*NUM_REQ-1:0] i_wb_adr;
  logic [8*NUM_REQ-1:0] i_wb_dat;
  logic [NUM_REQ-1:0]   i_wb_we;
  logic [NUM_REQ-1:0]   i_wb_stb;
  logic [NUM_REQ-1:0]   i_wb_cyc;
  logic [7:0]           o_wb_dat;
  logic [NUM_REQ-1:0]   o_wb_ack;
  logic [2:0]           o_m_adr;
  logic [7:0]           o_m_dat;
  logic                 o_m_we;
  logic                 o_m_stb;
  logic                 o_m_cyc;
  logic [7:0]           i_m_dat;
  logic                 i_m_ack;
  logic                 o_busy;
  logic                 o_timeout;
  modport slave (
    input  i_req, i_wb_adr, i_wb_dat, i_wb_we, i_wb_stb, i_wb_cyc, i_m_dat, i_m_ack,
    output o_gnt, o_wb_dat, o_wb_ack, o_m_adr, o_m_dat, o_m_we, o_m_stb, o_m_cyc, o_busy, o_timeout
  );
  modport master (
    output i_req, i_wb_adr, i_wb_dat, i_wb_we, i_wb_stb, i_wb_cyc, i_m_dat, i_m_ack,
    input  o_gnt, o_wb_dat, o_wb_ack, o_m_adr, o_m_dat, o_m_we, o_m_stb, o_m_cyc, o_busy, o_timeout
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin, whole-transaction owner of one shared Wishbone I2C master; define ARB_TIMEOUT_EN for the stalled-owner watchdog
module i2c_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input logic              i_clk,
  input logic              i_reset,
  i2c_bus_arbiter_if.slave bus
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, BLOCK} state_t;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] blk_q, blk_d;
  logic               tmo_q, tmo_d;
`else
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;
  logic unused_cfg;
  assign unused_cfg = |TIMEOUT_CYCLES;
`endif
  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, avail;
  logic [PW-1:0]      ptr_q, ptr_d, pick;
  logic [2:0]         adr_a [NUM_REQ];
  logic [7:0]         dat_a [NUM_REQ];
  logic               busy, own_req, own_cyc;
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign adr_a[k] = bus.i_wb_adr[3*k +: 3];
    assign dat_a[k] = bus.i_wb_dat[8*k +: 8];
  end
  assign busy         = |gnt_q;
  assign own_req      = bus.i_req[ptr_q];
  assign own_cyc      = bus.i_wb_cyc[ptr_q];
  assign bus.o_gnt    = gnt_q;
  assign bus.o_busy   = busy;
  assign bus.o_wb_dat = bus.i_m_dat;
  assign bus.o_wb_ack = {NUM_REQ{bus.i_m_ack}} & gnt_q;
  assign bus.o_m_adr  = busy ? adr_a[ptr_q] : '0;
  assign bus.o_m_dat  = busy ? dat_a[ptr_q] : '0;
  assign bus.o_m_we   = busy & bus.i_wb_we[ptr_q];
  assign bus.o_m_stb  = busy & bus.i_wb_stb[ptr_q];
  assign bus.o_m_cyc  = busy & own_cyc;
`ifdef ARB_TIMEOUT_EN
  assign bus.o_timeout = tmo_q;
  assign avail         = bus.i_req & ~blk_q;
`else
  assign bus.o_timeout = 1'b0;
  assign avail         = bus.i_req;
`endif
  // first available requester after the last owner, wrapping around
  always_comb begin
    pick = ptr_q;
    for (int i = NUM_REQ; i >= 1; i--)
      if (avail[PW'((int'(ptr_q) + i) % NUM_REQ)]) pick = PW'((int'(ptr_q) + i) % NUM_REQ);
  end
  // ownership sequencing: grant from idle, hold for the transaction, drain the in-flight access
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d = ((state_q == GRANT || state_q == DRAIN) && !bus.i_m_ack) ? cnt_q + 1'b1 : '0;
    blk_d = blk_q & bus.i_req;
    tmo_d = 1'b0;
`endif
    case (state_q)
      GRANT: begin
        if (!own_req) begin
          state_d = own_cyc ? DRAIN : IDLE;
          gnt_d   = own_cyc ? gnt_q : '0;
        end
      end
      DRAIN: begin
        if (bus.i_m_ack || !own_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = |avail ? GRANT : IDLE;
        if (|avail) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          ptr_d       = pick;
        end
      end
    endcase
`ifdef ARB_TIMEOUT_EN
    if ((state_q == GRANT || state_q == DRAIN) && state_d != IDLE && !bus.i_m_ack &&
        cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
      state_d      = BLOCK;
      gnt_d        = '0;
      tmo_d        = 1'b1;
      blk_d[ptr_q] = own_req;
    end
`endif
  end
  // state, grant and last-owner pointer
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= PW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end
`ifdef ARB_TIMEOUT_EN
  // watchdog counter, blocked-requester mask and revoke pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
      blk_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      blk_q <= blk_d;
      tmo_q <= tmo_d;
    end
  end
`endif
endmodule
